mc_control_unit: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 215 +++++++++++++++++++++
 rtl/mc_wait_counter.sv | 39 +++
 rtl/mc_control_unit.sv | 136 +++++++++++++
 tb/tb_mc_control_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - states, opcodes, select encodings and per-state control decode for mc_control_unit
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RESET,
      S_FETCH,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_ADDI,
      S_WB_I,
      S_JR,
      S_ADDR,
      S_LW_MEM,
      S_LW_WAIT,
      S_LW_WB,
      S_SW_MEM,
      S_BRANCH,
      S_JUMP,
      S_JAL,
      S_EXC_OPC,
      S_EXC_OVF,
      S_EXC_WAIT,
      S_EXC_LOAD
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   localparam logic [2:0] IORD_PC      = 3'd0;
   localparam logic [2:0] IORD_ALUOUT  = 3'd1;
   localparam logic [2:0] IORD_EXC_OPC = 3'd2;
   localparam logic [2:0] IORD_EXC_OVF = 3'd3;
   localparam logic [2:0] IORD_C255    = 3'd4;

   localparam logic [1:0] RDST_RT = 2'd0;
   localparam logic [1:0] RDST_RD = 2'd1;
   localparam logic [1:0] RDST_31 = 2'd2;
   localparam logic [1:0] RDST_SP = 2'd3;

   localparam logic [2:0] M2R_ALUOUT = 3'd0;
   localparam logic [2:0] M2R_MDR    = 3'd1;
   localparam logic [2:0] M2R_C227   = 3'd2;
   localparam logic [2:0] M2R_PC     = 3'd3;

   localparam logic       SRCA_PC = 1'b0;
   localparam logic       SRCA_A  = 1'b1;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [2:0] ALU_PASSA = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;

   localparam logic [2:0] PCS_ALU      = 3'd0;
   localparam logic [2:0] PCS_ALUOUT   = 3'd1;
   localparam logic [2:0] PCS_JUMP     = 3'd2;
   localparam logic [2:0] PCS_A        = 3'd3;
   localparam logic [2:0] PCS_MDR_BYTE = 3'd4;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       ab_write;
      logic       alu_out_write;
      logic       mdr_write;
      logic       epc_write;
      logic [2:0] iord;
      logic [1:0] reg_dst;
      logic [2:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [2:0] pc_source;
      logic [1:0] branch_ctrl;
   } ctl_t;

   // R-type ALU operation; only add/sub/and ever reach EXEC_R
   function automatic logic [2:0] funct_alu_op(logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

   // Control word for a state; last marks the final wait count, held_iord keeps the exception vector
   function automatic ctl_t ctl_for(state_e s, logic last, logic br_ne,
                                    logic [2:0] r_alu_op, logic [2:0] held_iord);
      ctl_t c;
      c = '0;
      case (s)
         S_RESET: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RDST_SP;
            c.mem_to_reg = M2R_C227;
         end
         S_FETCH: c.iord = IORD_PC;
         S_FETCH_WAIT: begin
            c.iord = IORD_PC;
            if (last) begin
               c.ir_write  = 1'b1;
               c.pc_write  = 1'b1;
               c.alu_src_a = SRCA_PC;
               c.alu_src_b = SRCB_FOUR;
               c.alu_op    = ALU_ADD;
               c.pc_source = PCS_ALU;
            end
         end
         S_DECODE: begin
            c.ab_write      = 1'b1;
            c.alu_out_write = 1'b1;
            c.alu_src_a     = SRCA_PC;
            c.alu_src_b     = SRCB_IMM_SH;
            c.alu_op        = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a     = SRCA_A;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = r_alu_op;
            c.alu_out_write = 1'b1;
         end
         S_WB_R: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RDST_RD;
            c.mem_to_reg = M2R_ALUOUT;
         end
         S_ADDI, S_ADDR: begin
            c.alu_src_a     = SRCA_A;
            c.alu_src_b     = SRCB_IMM;
            c.alu_op        = ALU_ADD;
            c.alu_out_write = 1'b1;
         end
         S_WB_I: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RDST_RT;
            c.mem_to_reg = M2R_ALUOUT;
         end
         S_JR: begin
            c.pc_source = PCS_A;
            c.pc_write  = 1'b1;
         end
         S_LW_MEM: c.iord = IORD_ALUOUT;
         S_LW_WAIT: begin
            c.iord      = IORD_ALUOUT;
            c.mdr_write = last;
         end
         S_LW_WB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = RDST_RT;
            c.mem_to_reg = M2R_MDR;
         end
         S_SW_MEM: begin
            c.iord      = IORD_ALUOUT;
            c.mem_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = SRCA_A;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_SUB;
            c.pc_source     = PCS_ALUOUT;
            c.pc_write_cond = 1'b1;
            c.branch_ctrl   = {1'b0, br_ne};
         end
         S_JUMP: begin
            c.pc_source = PCS_JUMP;
            c.pc_write  = 1'b1;
         end
         S_JAL: begin
            c.pc_source  = PCS_JUMP;
            c.pc_write   = 1'b1;
            c.reg_write  = 1'b1;
            c.reg_dst    = RDST_31;
            c.mem_to_reg = M2R_PC;
         end
         S_EXC_OPC, S_EXC_OVF: begin
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALU_SUB;
            c.epc_write = 1'b1;
            c.iord      = (s == S_EXC_OVF) ? IORD_EXC_OVF : IORD_EXC_OPC;
         end
         S_EXC_WAIT: begin
            c.iord      = held_iord;
            c.mdr_write = last;
         end
         S_EXC_LOAD: begin
            c.pc_source = PCS_MDR_BYTE;
            c.pc_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// rtl/mc_wait_counter.sv - memory wait-state down counter with last-cycle flags
module mc_wait_counter #(
   parameter int MEM_WAIT_CYCLES = 1
) (
   input  logic clk_i,
   input  logic clear_i,
   input  logic load_i,
   input  logic dec_i,
   output logic last_o,
   output logic last_next_o
);

   localparam int CW = $clog2(MEM_WAIT_CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear wins over load, load over decrement; the count parks at zero
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = CW'(MEM_WAIT_CYCLES);
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i) begin
      count_q <= count_d;
   end

   // last_next_o lets the FSM register outputs for the cycle that will be final
   assign last_o      = (count_q == CW'(1));
   assign last_next_o = (count_d == CW'(1));

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle MIPS Moore control FSM; OVERFLOW_EXC_EN enables overflow exceptions
module mc_control_unit #(
   parameter int MEM_WAIT_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       overflow_i,
   input  logic       zero_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_write_o,
   output logic       ab_write_o,
   output logic       alu_out_write_o,
   output logic       mdr_write_o,
   output logic       epc_write_o,
   output logic [2:0] iord_o,
   output logic [1:0] reg_dst_o,
   output logic [2:0] mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic [2:0] pc_source_o,
   output logic [1:0] branch_ctrl_o
);

   import mc_ctrl_pkg::*;

   state_e state_q;
   state_e state_d;
   ctl_t   ctl_q;
   logic   cnt_load;
   logic   cnt_dec;
   logic   cnt_last;
   logic   cnt_last_next;
   logic   unused_inputs;

   // Branch resolution happens in the datapath; overflow is only consulted when exceptions are built in
   assign unused_inputs = ^{zero_i, overflow_i};

   mc_wait_counter #(
      .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
   ) u_wait (
      .clk_i      (clock),
      .clear_i    (~reset),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .last_o     (cnt_last),
      .last_next_o(cnt_last_next)
   );

   // Memory-access states arm the counter; wait states consume it
   always_comb begin
      cnt_load = (state_q == S_FETCH) || (state_q == S_LW_MEM) ||
                 (state_q == S_EXC_OPC) || (state_q == S_EXC_OVF);
      cnt_dec  = (state_q == S_FETCH_WAIT) || (state_q == S_LW_WAIT) ||
                 (state_q == S_EXC_WAIT);
   end

   // Next-state selection, including opcode/funct dispatch out of DECODE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:      state_d = S_FETCH;
         S_FETCH:      state_d = S_FETCH_WAIT;
         S_FETCH_WAIT: if (cnt_last) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_RTYPE: begin
                  case (funct_i)
                     FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                     FN_JR:                  state_d = S_JR;
                     default:                state_d = S_EXC_OPC;
                  endcase
               end
               OP_ADDI:       state_d = S_ADDI;
               OP_LW, OP_SW:  state_d = S_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_JAL:        state_d = S_JAL;
               default:       state_d = S_EXC_OPC;
            endcase
         end
`ifdef OVERFLOW_EXC_EN
         S_EXEC_R: state_d = (overflow_i && (funct_i != FN_AND)) ? S_EXC_OVF : S_WB_R;
         S_ADDI:   state_d = overflow_i ? S_EXC_OVF : S_WB_I;
`else
         S_EXEC_R: state_d = S_WB_R;
         S_ADDI:   state_d = S_WB_I;
`endif
         S_ADDR:     state_d = (opcode_i == OP_LW) ? S_LW_MEM : S_SW_MEM;
         S_LW_MEM:   state_d = S_LW_WAIT;
         S_LW_WAIT:  if (cnt_last) state_d = S_LW_WB;
         S_EXC_OPC,
         S_EXC_OVF:  state_d = S_EXC_WAIT;
         S_EXC_WAIT: if (cnt_last) state_d = S_EXC_LOAD;
         S_WB_R, S_WB_I, S_JR, S_LW_WB, S_SW_MEM,
         S_BRANCH, S_JUMP, S_JAL, S_EXC_LOAD: state_d = S_FETCH;
         default:    state_d = S_RESET;
      endcase
   end

   // State and registered Moore outputs; the control word is decoded from the state being entered
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_RESET;
         ctl_q   <= ctl_for(S_RESET, 1'b0, 1'b0, ALU_PASSA, IORD_PC);
      end else begin
         state_q <= state_d;
         ctl_q   <= ctl_for(state_d, cnt_last_next, opcode_i[0],
                            funct_alu_op(funct_i), ctl_q.iord);
      end
   end

   assign pc_write_o      = ctl_q.pc_write;
   assign pc_write_cond_o = ctl_q.pc_write_cond;
   assign mem_write_o     = ctl_q.mem_write;
   assign ir_write_o      = ctl_q.ir_write;
   assign reg_write_o     = ctl_q.reg_write;
   assign ab_write_o      = ctl_q.ab_write;
   assign alu_out_write_o = ctl_q.alu_out_write;
   assign mdr_write_o     = ctl_q.mdr_write;
   assign epc_write_o     = ctl_q.epc_write;
   assign iord_o          = ctl_q.iord;
   assign reg_dst_o       = ctl_q.reg_dst;
   assign mem_to_reg_o    = ctl_q.mem_to_reg;
   assign alu_src_a_o     = ctl_q.alu_src_a;
   assign alu_src_b_o     = ctl_q.alu_src_b;
   assign alu_op_o        = ctl_q.alu_op;
   assign pc_source_o     = ctl_q.pc_source;
   assign branch_ctrl_o   = ctl_q.branch_ctrl;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - table-driven bench for mc_control_unit at MEM_WAIT_CYCLES 1 and 3
module tb_mc_control_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // index 0: MEM_WAIT_CYCLES=1 instance, index 1: MEM_WAIT_CYCLES=3 instance
   logic [1:0] rst, ov, zero;
   logic [5:0] op [2];
   logic [5:0] fn [2];
   logic [1:0] pc_write, pc_write_cond, mem_write, ir_write, reg_write;
   logic [1:0] ab_write, alu_out_write, mdr_write, epc_write, alu_src_a;
   logic [2:0] iord [2];
   logic [2:0] mem_to_reg [2];
   logic [2:0] alu_op [2];
   logic [2:0] pc_source [2];
   logic [1:0] reg_dst [2];
   logic [1:0] alu_src_b [2];
   logic [1:0] branch_ctrl [2];

   int checks = 0;
   int errors = 0;

   mc_control_unit #(.MEM_WAIT_CYCLES(1)) dut1 (
      .clock(clk), .reset(rst[0]), .opcode_i(op[0]), .funct_i(fn[0]),
      .overflow_i(ov[0]), .zero_i(zero[0]),
      .pc_write_o(pc_write[0]), .pc_write_cond_o(pc_write_cond[0]),
      .mem_write_o(mem_write[0]), .ir_write_o(ir_write[0]),
      .reg_write_o(reg_write[0]), .ab_write_o(ab_write[0]),
      .alu_out_write_o(alu_out_write[0]), .mdr_write_o(mdr_write[0]),
      .epc_write_o(epc_write[0]), .iord_o(iord[0]), .reg_dst_o(reg_dst[0]),
      .mem_to_reg_o(mem_to_reg[0]), .alu_src_a_o(alu_src_a[0]),
      .alu_src_b_o(alu_src_b[0]), .alu_op_o(alu_op[0]),
      .pc_source_o(pc_source[0]), .branch_ctrl_o(branch_ctrl[0])
   );

   mc_control_unit #(.MEM_WAIT_CYCLES(3)) dut3 (
      .clock(clk), .reset(rst[1]), .opcode_i(op[1]), .funct_i(fn[1]),
      .overflow_i(ov[1]), .zero_i(zero[1]),
      .pc_write_o(pc_write[1]), .pc_write_cond_o(pc_write_cond[1]),
      .mem_write_o(mem_write[1]), .ir_write_o(ir_write[1]),
      .reg_write_o(reg_write[1]), .ab_write_o(ab_write[1]),
      .alu_out_write_o(alu_out_write[1]), .mdr_write_o(mdr_write[1]),
      .epc_write_o(epc_write[1]), .iord_o(iord[1]), .reg_dst_o(reg_dst[1]),
      .mem_to_reg_o(mem_to_reg[1]), .alu_src_a_o(alu_src_a[1]),
      .alu_src_b_o(alu_src_b[1]), .alu_op_o(alu_op[1]),
      .pc_source_o(pc_source[1]), .branch_ctrl_o(branch_ctrl[1])
   );

   // we = {pc_write, pc_write_cond, mem_write, ir_write, reg_write, ab_write, alu_out_write, mdr_write, epc_write}
   function automatic logic [27:0] cv(logic [8:0] we, int io, int rd, int m2r, int a, int b,
                                      int aop, int pcs, int br);
      return {we, 3'(io), 2'(rd), 3'(m2r), 1'(a), 2'(b), 3'(aop), 3'(pcs), 2'(br)};
   endfunction

   function automatic logic [27:0] obs(bit d);
      return {pc_write[d], pc_write_cond[d], mem_write[d], ir_write[d], reg_write[d],
              ab_write[d], alu_out_write[d], mdr_write[d], epc_write[d], iord[d],
              reg_dst[d], mem_to_reg[d], alu_src_a[d], alu_src_b[d], alu_op[d],
              pc_source[d], branch_ctrl[d]};
   endfunction

   task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %07h want %07h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        ov;
      int          per;
      int          off;
      logic [27:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input int o, input int f, input int v,
                      input int per, input int off, input logic [27:0] exp);
      vec_t r;
      r.name = nm; r.op = 6'(o); r.fn = 6'(f); r.ov = 1'(v);
      r.per = per; r.off = off; r.exp = exp;
      tbl.push_back(r);
   endtask

   logic [27:0] v_reset, v_fw, v_exec_add, v_wb_r, v_wb_i, v_imm, v_exc_opc;

   initial begin
      int  cyc;
      bit  got;
      bit  mdr_seen;

      v_reset    = cv(9'b000010000, 0, 3, 2, 0, 0, 0, 0, 0);
      v_fw       = cv(9'b100100000, 0, 0, 0, 0, 1, 1, 0, 0);
      v_exec_add = cv(9'b000000100, 0, 0, 0, 1, 0, 1, 0, 0);
      v_wb_r     = cv(9'b000010000, 0, 1, 0, 0, 0, 0, 0, 0);
      v_wb_i     = cv(9'b000010000, 0, 0, 0, 0, 0, 0, 0, 0);
      v_imm      = cv(9'b000000100, 0, 0, 0, 1, 2, 1, 0, 0);
      v_exc_opc  = cv(9'b000000001, 2, 0, 0, 0, 1, 2, 0, 0);

      add("decode",   'h00, 'h20, 0, 5, 1, cv(9'b000001100, 0, 0, 0, 0, 3, 1, 0, 0));
      add("add_exec", 'h00, 'h20, 0, 5, 2, v_exec_add);
      add("add_wb",   'h00, 'h20, 0, 5, 3, v_wb_r);
      add("sub_exec", 'h00, 'h22, 0, 5, 2, cv(9'b000000100, 0, 0, 0, 1, 0, 2, 0, 0));
      add("and_exec", 'h00, 'h24, 0, 5, 2, cv(9'b000000100, 0, 0, 0, 1, 0, 3, 0, 0));
      add("addi_ex",  'h08, 'h00, 0, 5, 2, v_imm);
      add("addi_wb",  'h08, 'h00, 0, 5, 3, v_wb_i);
      add("lw_addr",  'h23, 'h00, 0, 7, 2, v_imm);
      add("lw_mem",   'h23, 'h00, 0, 7, 3, cv(9'b000000000, 1, 0, 0, 0, 0, 0, 0, 0));
      add("lw_wait",  'h23, 'h00, 0, 7, 4, cv(9'b000000010, 1, 0, 0, 0, 0, 0, 0, 0));
      add("lw_wb",    'h23, 'h00, 0, 7, 5, cv(9'b000010000, 0, 0, 1, 0, 0, 0, 0, 0));
      add("sw_mem",   'h2B, 'h00, 0, 5, 3, cv(9'b001000000, 1, 0, 0, 0, 0, 0, 0, 0));
      add("beq",      'h04, 'h00, 0, 4, 2, cv(9'b010000000, 0, 0, 0, 1, 0, 2, 1, 0));
      add("bne",      'h05, 'h00, 0, 4, 2, cv(9'b010000000, 0, 0, 0, 1, 0, 2, 1, 1));
      add("j",        'h02, 'h00, 0, 4, 2, cv(9'b100000000, 0, 0, 0, 0, 0, 0, 2, 0));
      add("jal",      'h03, 'h00, 0, 4, 2, cv(9'b100010000, 0, 2, 3, 0, 0, 0, 2, 0));
      add("jr",       'h00, 'h08, 0, 4, 2, cv(9'b100000000, 0, 0, 0, 0, 0, 0, 3, 0));
      add("opc_exc",  'h3F, 'h00, 0, 6, 2, v_exc_opc);
      add("opc_wait", 'h3F, 'h00, 0, 6, 3, cv(9'b000000010, 2, 0, 0, 0, 0, 0, 0, 0));
      add("opc_load", 'h3F, 'h00, 0, 6, 4, cv(9'b100000000, 0, 0, 0, 0, 0, 0, 4, 0));
      add("opc_fet",  'h3F, 'h00, 0, 6, 5, cv(9'b000000000, 0, 0, 0, 0, 0, 0, 0, 0));
      add("fn_exc",   'h00, 'h21, 0, 6, 2, v_exc_opc);
      add("and_ovf",  'h00, 'h24, 1, 5, 3, v_wb_r);
`ifdef OVERFLOW_EXC_EN
      add("add_ovf",  'h00, 'h20, 1, 7, 3, cv(9'b000000001, 3, 0, 0, 0, 1, 2, 0, 0));
      add("add_ovfw", 'h00, 'h20, 1, 7, 4, cv(9'b000000010, 3, 0, 0, 0, 0, 0, 0, 0));
      add("addi_ovf", 'h08, 'h00, 1, 7, 3, cv(9'b000000001, 3, 0, 0, 0, 1, 2, 0, 0));
`else
      add("add_ovf",  'h00, 'h20, 1, 5, 3, v_wb_r);
      add("add_ovfx", 'h00, 'h20, 1, 5, 2, v_exec_add);
      add("addi_ovf", 'h08, 'h00, 1, 5, 3, v_wb_i);
`endif

      rst = 2'b00; ov = 2'b00; zero = 2'b00;
      op[0] = 6'h00; fn[0] = 6'h20; op[1] = 6'h00; fn[1] = 6'h20;

      // Reset values, held over several cycles, then release
      repeat (3) @(negedge clk);
      chk("reset_dut1", obs(0), v_reset);
      chk("reset_dut3", obs(1), v_reset);
      rst = 2'b11;
      @(negedge clk);
      chk("fetch_dut1", obs(0), 28'h0);
      chk("fetch_dut3", obs(1), 28'h0);
      @(negedge clk);
      chk("first_ir_dut1", obs(0), v_fw);

      // Each row starts at an ir_write cycle and runs until the next one
      foreach (tbl[i]) begin
         op[0] = tbl[i].op; fn[0] = tbl[i].fn; ov[0] = tbl[i].ov;
         cyc = 0; got = 0;
         while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == tbl[i].off) chk(tbl[i].name, obs(0), tbl[i].exp);
            if (ir_write[0]) got = 1'b1;
         end
         chki({tbl[i].name, "_period"}, cyc, tbl[i].per);
         chk({tbl[i].name, "_fw"}, obs(0), v_fw);
      end
      ov[0] = 1'b0;

      // lw with three wait cycles on the second instance
      cyc = 0; got = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (ir_write[1]) got = 1'b1;
      end
      chki("dut3_sync", int'(got), 1);
      op[1] = 6'h23; fn[1] = 6'h00;
      cyc = 0; got = 0;
      while (!got && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (cyc == 4 || cyc == 5) chki($sformatf("lw3_nomdr_c%0d", cyc), int'(mdr_write[1]), 0);
         if (cyc == 6) chk("lw3_mdr", obs(1), cv(9'b000000010, 1, 0, 0, 0, 0, 0, 0, 0));
         if (cyc == 7) chk("lw3_wb", obs(1), cv(9'b000010000, 0, 0, 1, 0, 0, 0, 0, 0));
         if (ir_write[1]) got = 1'b1;
      end
      chki("lw3_period", cyc, 11);

      // Reset during LW_WAIT: back to RESET, no MDR load, counter restarts cleanly
      mdr_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mdr_write[1]) mdr_seen = 1'b1;
      end
      chk("lw3_in_wait", obs(1), cv(9'b000000000, 1, 0, 0, 0, 0, 0, 0, 0));
      rst[1] = 1'b0;
      @(negedge clk);
      chk("lw3_rst_state", obs(1), v_reset);
      @(negedge clk);
      if (mdr_write[1]) mdr_seen = 1'b1;
      rst[1] = 1'b1;
      @(negedge clk);
      chk("lw3_rel_fetch", obs(1), 28'h0);
      cyc = 1; got = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (mdr_write[1]) mdr_seen = 1'b1;
         if (ir_write[1]) got = 1'b1;
      end
      chki("lw3_rst_refetch", cyc, 4);
      chki("lw3_mdr_never", int'(mdr_seen), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
